// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
// State encoding plus default widths, timeout and sync depth.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned TIMEOUT_DEF = 1048576;
    localparam int unsigned SYNC_MIN    = 2;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Synchronizer chain plus history flop producing rise/fall strobes.
// Ports: clk, rst (async active-low), sig_in -> rise, fall.
module period_meter_sync_edge_detect
    import period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist   <= sync;
        end
    end

    assign rise = sync & ~hist;
    assign fall = ~sync & hist;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// Ports: clk, rst (async active-low), enable, sig_in -> period,
// high_time, meas_valid (pulse), locked (level), timeout (sticky).
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_hold;
    logic [MW-1:0]    match;
    logic [MW-1:0]    nxt_match;
    logic             rise;
    logic             fall;

    period_meter_sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .sig_in(sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign cnt_inc = cnt + 1'b1;

    // The new period is cnt+1; compare it against the last reported one.
    always_comb begin
        nxt_match = MW'(1);
        if (cnt_inc == period) begin
            if (match == MATCH_MAX)
                nxt_match = match;
            else
                nxt_match = match + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            high_hold  <= '0;
            match      <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                cnt       <= '0;
                high_hold <= '0;
                match     <= '0;
                locked    <= 1'b0;
                timeout   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt       <= '0;
                            high_hold <= '0;
                            state     <= MEASURE;
                        end else if (cnt == TO_LAST) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            match   <= '0;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period     <= cnt_inc;
                            high_time  <= high_hold;
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            match      <= nxt_match;
                            locked     <= (nxt_match == MATCH_MAX);
                            cnt        <= '0;
                        end else if (cnt == TO_LAST) begin
                            // Signal stalled: restart from the first rise.
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            match   <= '0;
                            cnt     <= '0;
                            state   <= ARM;
                        end else begin
                            cnt <= cnt_inc;
                            if (fall)
                                high_hold <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed plus randomized bench for period_meter.
// Cycle-level reference model built from rise times and pulse widths.
module tb_period_meter;

    localparam int CW   = 32;
    localparam int SS   = 2;
    localparam int LOCK = 4;
    localparam int TO   = 64;
    localparam int LAT  = SS + 1;

    typedef struct {
        int c;
        int h;
    } rise_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          locked;
    logic          timeout;

    period_meter #(
        .CNT_W      (CW),
        .SYNC_STAGES(SS),
        .LOCK_COUNT (LOCK),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    errors  = 0;
    int    cyc     = 0;
    rise_t rq[$];

    bit idle      = 1'b1;
    bit have_prev = 1'b0;
    int prev_rise = 0;
    int prev_hi   = 0;
    int deadline  = 0;
    int match     = 0;
    int m_per     = 0;
    int m_high    = 0;
    bit m_lock    = 1'b0;
    bit m_to      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        idle      = 1'b1;
        have_prev = 1'b0;
        match     = 0;
        m_per     = 0;
        m_high    = 0;
        m_lock    = 1'b0;
        m_to      = 1'b0;
        rq.delete();
    endtask

    task automatic check_all(input bit mv);
        chk("meas_valid", {31'd0, meas_valid}, {31'd0, mv});
        chk("period", period, m_per);
        chk("high_time", high_time, m_high);
        chk("locked", {31'd0, locked}, {31'd0, m_lock});
        chk("timeout", {31'd0, timeout}, {31'd0, m_to});
    endtask

    task automatic tick();
        bit    due;
        bit    mv;
        rise_t r;
        int    per;
        @(posedge clk);
        cyc++;
        mv  = 1'b0;
        due = (rq.size() > 0) && (rq[0].c + LAT == cyc);
        if (due)
            r = rq.pop_front();
        if (!rst) begin
        end else if (!enable) begin
            idle      = 1'b1;
            have_prev = 1'b0;
            match     = 0;
            m_lock    = 1'b0;
            m_to      = 1'b0;
        end else if (idle) begin
            idle     = 1'b0;
            deadline = cyc + TO;
        end else if (due) begin
            if (have_prev) begin
                per = cyc - prev_rise;
                if (per == m_per)
                    match = (match < LOCK) ? match + 1 : LOCK;
                else
                    match = 1;
                m_per  = per;
                m_high = prev_hi;
                m_lock = (match == LOCK);
                m_to   = 1'b0;
                mv     = 1'b1;
            end
            have_prev = 1'b1;
            prev_rise = cyc;
            prev_hi   = r.h;
            deadline  = cyc + TO;
        end else if (cyc == deadline) begin
            m_to      = 1'b1;
            m_lock    = 1'b0;
            match     = 0;
            have_prev = 1'b0;
            deadline  = cyc + TO;
        end
        #1;
        check_all(mv);
    endtask

    task automatic pulse(input int hi, input int lo);
        rise_t r;
        sig_in = 1'b1;
        r.c = cyc;
        r.h = hi;
        rq.push_back(r);
        repeat (hi) tick();
        sig_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic pulses(input int hi, input int lo, input int n);
        repeat (n) pulse(hi, lo);
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(1'b0);
    endtask

    initial begin
        int hi;
        int lo;
        int n;
        #2;
        rst = 1'b0;
        #1;
        check_all(1'b0);
        repeat (3) tick();
        rst    = 1'b1;
        enable = 1'b1;
        repeat (3) tick();

        pulses(2, 2, 8);
        pulses(5, 5, 8);
        pulses(5, 5, 3);
        pulses(6, 6, 1);
        pulses(6, 6, 5);

        pulses(5, 5, 6);
        repeat (80) tick();
        pulses(5, 5, 3);

        for (int g = 0; g < 20; g++) begin
            hi = $urandom_range(6, 1);
            lo = $urandom_range(6, 1);
            n  = $urandom_range(6, 1);
            pulses(hi, lo, n);
        end

        pulses(5, 5, 6);
        pulse(5, 2);
        async_reset();
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        pulses(5, 5, 4);

        pulses(4, 4, 6);
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (3) tick();
        pulses(4, 4, 6);
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures a slow, clock-derived square wave (e.g. the output of the team's clock divider) in units of the system clock.
- Reports the period and high time of the input, and flags lock when consecutive periods match.
- Flags a timeout when the input stops toggling.
- Sits on the receive side of a divided-clock link: loopback self-check, divider-ratio recovery, and frequency monitoring.

Parameters:
- CNT_W, 32: width of the cycle counter and of the period/high_time outputs.
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer, minimum 2.
- LOCK_COUNT, 4: number of consecutive identical period measurements required to assert locked, minimum 2.
- TIMEOUT, 1048576: cycles without a rising edge before timeout; must be at most 2^CNT_W - 1.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: reset; asynchronous assert, active-low (0 = reset), deassertion synchronous to clk.
- enable, input, 1: measurement enable; 0 forces IDLE.
- sig_in, input, 1: measured signal; asynchronous to clk.
- period, output, CNT_W: last measured rising-to-rising distance, in clk cycles.
- high_time, output, CNT_W: high time belonging to the last period, in clk cycles.
- meas_valid, output, 1: one-cycle pulse when period/high_time update.
- locked, output, 1: level; LOCK_COUNT consecutive equal periods have been seen.
- timeout, output, 1: sticky level; no rising edge within TIMEOUT cycles.

Behaviour:
- Reset: all outputs 0, all counters 0, synchronizer 0, state IDLE.
- Input path:
  - sig_in passes through SYNC_STAGES flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - An edge on sig_in is detected SYNC_STAGES+1 cycles later, with ±1 cycle metastability uncertainty.
- FSM states: IDLE, ARM, MEASURE.
- IDLE:
  - enable=1 → ARM.
  - cnt, match count, hold registers and locked cleared.
  - period/high_time keep their last values; timeout cleared.
- ARM:
  - Waits for the first rise; fall is ignored.
  - cnt increments each cycle.
  - On rise: cnt ← 0, high_hold ← 0, go to MEASURE. No meas_valid.
- MEASURE:
  - cnt increments each cycle.
  - On fall: high_hold ← cnt + 1.
  - On rise:
    - period ← cnt + 1, high_time ← high_hold, meas_valid=1 on the next cycle.
    - cnt ← 0; stay in MEASURE.
  - A signal with period P cycles and high time H therefore reports period=P, high_time=H. Minimum measurable P is 2.
- Lock:
  - On each measurement, if the new period equals the previous period, match count increments (saturating at LOCK_COUNT); otherwise it resets to 1.
  - locked = (match count == LOCK_COUNT), updated in the same cycle as meas_valid.
  - A mismatch drops locked together with that meas_valid.
- Timeout:
  - In ARM or MEASURE, if cnt == TIMEOUT-1 and there is no rise this cycle: timeout ← 1, locked ← 0, match count ← 0, cnt ← 0, state ← ARM.
  - timeout stays set until the next meas_valid or until enable=0.
- Simultaneous events:
  - rise and timeout in the same cycle: rise wins.
  - rise and fall cannot coincide.
  - enable=0 has priority over everything: next state is IDLE and no meas_valid is produced.
- Reset mid-measurement: immediate return to the reset state. The first measurement after release needs two rises.
- Arithmetic: cnt is unsigned CNT_W; it never wraps because TIMEOUT ≤ 2^CNT_W - 1.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ARM, MEASURE);
  - the default CNT_W and TIMEOUT constants;
  - the minimum SYNC_STAGES constant.
- One natural sub-module: sync_edge_detect, containing the SYNC_STAGES synchronizer, the history flop, and the rise/fall outputs.

Test Plan:
- Divider ratio 2 drives sig_in (high 2, low 2 cycles) → after the second rise: period=4, high_time=2, meas_valid one cycle wide every 4 cycles.
- Divider ratio 5, LOCK_COUNT=4 → period=10, high_time=5; locked rises with the 4th meas_valid and stays high.
- Steady period 10, then a single period of 12 → that meas_valid reports 12 and locked drops; locked re-asserts after 4 equal periods at the new rate.
- TIMEOUT=64, sig_in held low after locking → timeout=1 exactly 64 cycles after the last rise counter clear, locked=0; the next two rises give meas_valid and clear timeout.
- rst pulled low mid-MEASURE → outputs 0 asynchronously; after release, the first rise produces no meas_valid and the second produces the correct period.
- enable dropped for 3 cycles → no meas_valid, locked=0, period holds its old value; re-enable requires two rises before a new measurement.
